// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready pipeline-stage register.
// A circular buffer of DEPTH entries sits between two core stages. Every
// output is driven from registered state, so there is no combinational
// path from input to output. Optional performance counters are enabled
// by defining PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_xfer
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  // Pointers wrap explicitly, so DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign s_ready = (cnt_q != CNT_W'(DEPTH));
  assign m_valid = (cnt_q != '0);
  assign m_data  = mem_q[rp_q];
  assign count   = cnt_q;
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  // Next state of the pointers and the count. Flush overrides any push or pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = ptr_inc(wp_q);
      if (pop)  rp_d = ptr_inc(rp_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage is not reset; a discarded push must not overwrite an entry.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wp_q] <= s_data;
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] stall_q, xfer_q;

  // Saturating stall and transfer counters; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      if (m_valid && !m_ready && !flush && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (pop && !flush && (xfer_q != '1))                  xfer_q  <= xfer_q + 32'd1;
    end
  end

  assign perf_stall = stall_q;
  assign perf_xfer  = xfer_q;
`else
  assign perf_stall = '0;
  assign perf_xfer  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: four instances (DEPTH 2,1,3,4) share clock and
// reset. A queue per instance holds the payloads accepted so far; each
// output transfer pops and compares, and occupancy/flags/perf counters are
// checked against the bench's own model after every clock.
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_BUF_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst;
  logic        fl [4], sv [4], sr [4], mv [4], mr [4];
  logic [31:0] sd [4], md [4], ps [4], px [4];
  logic [1:0]  c2, c3;
  logic [0:0]  c1;
  logic [2:0]  c4;
  int          dep [4] = '{2, 1, 3, 4};

  logic [31:0] q [4][$];
  int          mstall [4], mx [4];
  int          vectors = 0, miscompares = 0;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(fl[0]), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]), .count(c2),
    .perf_stall(ps[0]), .perf_xfer(px[0]));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]), .count(c1),
    .perf_stall(ps[1]), .perf_xfer(px[1]));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(fl[2]), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
    .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]), .count(c3),
    .perf_stall(ps[2]), .perf_xfer(px[2]));
  pipe_stage_buf #(.WIDTH(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .flush(fl[3]), .s_valid(sv[3]), .s_ready(sr[3]), .s_data(sd[3]),
    .m_valid(mv[3]), .m_ready(mr[3]), .m_data(md[3]), .count(c4),
    .perf_stall(ps[3]), .perf_xfer(px[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return 32'(c2);
      1:       return 32'(c1);
      2:       return 32'(c3);
      default: return 32'(c4);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      mstall[i] = 0;
      mx[i]     = 0;
    end
  endtask

  // Scoreboard the handshakes of the coming edge, clock once, then check
  // every instance's state. Called and returns just after a negedge.
  task automatic tick();
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      if (fl[i]) begin
        q[i].delete();
      end else begin
        if (mv[i] && !mr[i]) mstall[i]++;
        if (mv[i] && mr[i]) begin
          mx[i]++;
          if (q[i].size() == 0) chk("unexpected_pop", md[i], 32'hXXXX_XXXX);
          else begin
            e = q[i].pop_front();
            chk("m_data_order", md[i], e);
          end
        end
        if (sv[i] && sr[i]) q[i].push_back(sd[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("count", cnt_of(i), 32'(q[i].size()));
      chk("m_valid", 32'(mv[i]), 32'(q[i].size() != 0));
      chk("s_ready", 32'(sr[i]), 32'(q[i].size() != dep[i]));
      chk("perf_stall", ps[i], PERF ? 32'(mstall[i]) : 32'h0);
      chk("perf_xfer", px[i], PERF ? 32'(mx[i]) : 32'h0);
    end
  endtask

  initial begin
    int x0, p;
    logic pushed;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fl[i] = 1'b0; sv[i] = 1'b0; mr[i] = 1'b0; sd[i] = '0;
    end
    model_clear();
    #12;
    // Reset state
    for (int i = 0; i < 4; i++) begin
      chk("rst_m_valid", 32'(mv[i]), 32'h0);
      chk("rst_s_ready", 32'(sr[i]), 32'h1);
      chk("rst_count", cnt_of(i), 32'h0);
      chk("rst_perf_stall", ps[i], 32'h0);
      chk("rst_perf_xfer", px[i], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    // DEPTH=2: fill with m_ready low, head stays stable, then drain
    sv[0] = 1'b1; sd[0] = 32'h1111_1111; tick();
    sd[0] = 32'h2222_2222; tick();
    sv[0] = 1'b0;
    chk("t1_count_full", 32'(c2), 32'd2);
    chk("t1_s_ready_full", 32'(sr[0]), 32'd0);
    tick(); tick();
    chk("t1_head_stable", md[0], 32'h1111_1111);
    mr[0] = 1'b1;
    tick();
    chk("t1_second_head", md[0], 32'h2222_2222);
    tick();
    chk("t1_drained", 32'(mv[0]), 32'd0);

    // DEPTH=2: streaming 100 payloads at full rate
    sv[0] = 1'b1; mr[0] = 1'b1; x0 = mx[0];
    for (int k = 0; k < 100; k++) begin
      sd[0] = 32'(k);
      tick();
      chk("t2_count_le1", 32'(c2 <= 2'd1), 32'd1);
    end
    chk("t2_xfers", 32'(mx[0] - x0), 32'd99);
    sv[0] = 1'b0;
    tick();
    chk("t2_empty", 32'(mv[0]), 32'd0);

    // DEPTH=1: alternate accept/drain, 5 transfers in 10 cycles
    sv[1] = 1'b1; mr[1] = 1'b1; x0 = mx[1]; p = 32'hA0;
    for (int k = 0; k < 10; k++) begin
      sd[1] = 32'(p);
      chk("t3_s_ready_toggle", 32'(sr[1]), 32'((k % 2) == 0));
      pushed = sr[1];
      tick();
      if (pushed) p++;
    end
    chk("t3_xfers", 32'(mx[1] - x0), 32'd5);
    sv[1] = 1'b0;
    tick(); tick();

    // DEPTH=3: fill A,B,C; pop A; push D across the pointer wrap; drain
    sv[2] = 1'b1; mr[2] = 1'b0;
    sd[2] = 32'hAAAA_0001; tick();
    sd[2] = 32'hBBBB_0002; tick();
    sd[2] = 32'hCCCC_0003; tick();
    chk("t4_count3", 32'(c3), 32'd3);
    sv[2] = 1'b0; mr[2] = 1'b1; tick();
    chk("t4_count2", 32'(c3), 32'd2);
    sv[2] = 1'b1; mr[2] = 1'b0; sd[2] = 32'hDDDD_0004; tick();
    chk("t4_count3b", 32'(c3), 32'd3);
    sv[2] = 1'b0; mr[2] = 1'b1;
    chk("t4_head_B", md[2], 32'hBBBB_0002);
    tick(); tick(); tick();
    chk("t4_empty", 32'(c3), 32'd0);
    mr[2] = 1'b0;

    // DEPTH=4: flush with a coincident push and pop
    sv[3] = 1'b1; mr[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin sd[3] = 32'h4000 + 32'(k); tick(); end
    chk("t5_count3", 32'(c4), 32'd3);
    fl[3] = 1'b1; sd[3] = 32'hDEAD_BEEF; mr[3] = 1'b1; tick();
    fl[3] = 1'b0; sv[3] = 1'b0;
    chk("t5_flush_count", 32'(c4), 32'd0);
    chk("t5_flush_valid", 32'(mv[3]), 32'd0);
    tick(); tick();
    mr[3] = 1'b0;

    // Perf counters from a clean reset: 7 stall cycles, 3 transfers
    rst = 1'b0; model_clear(); #2;
    rst = 1'b1;
    sv[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin sd[3] = 32'h5000 + 32'(k); tick(); end
    sv[3] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    mr[3] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    mr[3] = 1'b0;
    chk("t6_perf_stall", ps[3], PERF ? 32'd7 : 32'd0);
    chk("t6_perf_xfer", px[3], PERF ? 32'd3 : 32'd0);

    // Asynchronous reset in the middle of a cycle
    sv[3] = 1'b1; sd[3] = 32'h6000_0001; tick();
    sd[3] = 32'h6000_0002; tick();
    sv[3] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t7_async_m_valid", 32'(mv[3]), 32'd0);
    chk("t7_async_count", 32'(c4), 32'd0);
    chk("t7_async_s_ready", 32'(sr[3]), 32'd1);
    chk("t7_async_perf_stall", ps[3], 32'd0);
    chk("t7_async_perf_xfer", px[3], 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
